// File: rtl/div_clk_strobe.sv
// Purpose: converts the asynchronous divided clock into clk_src-domain rise/fall enable strobes,
//          measures the rise-to-rise period and flags loss of the divided clock.
// Latency: SYNC_STAGES+1 flops from clk_div to en_rise/en_fall; period/period_valid one cycle after en_rise.
// Backpressure: none; strobes are free-running and consumers must sample them every cycle.
//
// Ports:
//   clk_src, rst_n   source clock, async active-low reset
//   clk_div          divided clock, asynchronous to clk_src
//   en_rise/en_fall  one-cycle strobes per clk_div rising/falling edge
//   period           clk_src cycles between the last two en_rise strobes (saturating)
//   period_valid     one-cycle strobe, period was just updated
//   lost             level, no rising edge seen for TIMEOUT cycles
//   edge_count       wrapping count of en_rise strobes
module div_clk_strobe #(
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk_src,
    input  logic                rst_n,
    input  logic                clk_div,
    output logic                en_rise,
    output logic                en_fall,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                lost,
    output logic [15:0]         edge_count
);

    localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);
    localparam logic [15:0] PERIOD_MAX = 16'((1 << PERIOD_W) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        LOST  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_vld_q;
    logic                   prev_q;
    logic                   prev_vld_q;
    logic                   sync_lvl;
    logic                   rise;
    logic                   fall;
    logic [15:0]            icnt;
    logic                   timeout;
    logic                   upd_period;
    logic [PERIOD_W-1:0]    period_sat;
    state_t                 state_q;
    state_t                 state_d;

    // The valid chain tracks which synchronizer samples came from clk_div rather than
    // from reset. A rise needs a genuine low in prev, so clk_div already high at reset
    // release does not produce a spurious strobe.
    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            sync_vld_q <= '0;
            prev_q     <= 1'b0;
            prev_vld_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], clk_div};
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
            prev_q     <= sync_q[SYNC_STAGES-1];
            prev_vld_q <= sync_vld_q[SYNC_STAGES-1];
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign rise     = sync_lvl & ~prev_q & prev_vld_q;
    // prev_q can only be 1 after a real high sample, so no validity qualifier needed.
    assign fall     = ~sync_lvl & prev_q;

    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            en_rise <= 1'b0;
            en_fall <= 1'b0;
        end else begin
            en_rise <= rise;
            en_fall <= fall;
        end
    end

    // icnt holds the number of cycles since the last en_rise cycle, so at the next
    // en_rise it equals the rise-to-rise period.
    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            icnt <= 16'd0;
        end else if (en_rise) begin
            icnt <= 16'd1;
        end else if (icnt != 16'hFFFF) begin
            icnt <= icnt + 16'd1;
        end
    end

    assign timeout    = (icnt == TIMEOUT_C);
    assign period_sat = (icnt > PERIOD_MAX) ? PERIOD_MAX[PERIOD_W-1:0] : icnt[PERIOD_W-1:0];

    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // en_rise has priority over timeout in every state.
    always_comb begin
        state_d    = state_q;
        upd_period = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_rise) begin
                    state_d = TRACK;
                end else if (timeout) begin
                    state_d = LOST;
                end
            end
            TRACK: begin
                if (en_rise) begin
                    upd_period = 1'b1;
                end else if (timeout) begin
                    state_d = LOST;
                end
            end
            LOST: begin
                if (en_rise) begin
                    state_d = TRACK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign lost = (state_q == LOST);

    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            period       <= '0;
            period_valid <= 1'b0;
            edge_count   <= 16'd0;
        end else begin
            period_valid <= upd_period;
            if (upd_period) begin
                period <= period_sat;
            end
            edge_count <= edge_count + 16'(en_rise);
        end
    end

endmodule
